// File: rtl/fixedpoint_pkg.sv
// Shared fixed-point number type and pipeline latencies of the fixed-point math units.
package fixedpoint;
    localparam int unsigned NUM_W     = 65;
    localparam int unsigned ATAN2_LAT = 37;

    typedef logic signed [NUM_W-1:0] number;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at an internal pointer,
// pointer moves past the winner whenever a grant is given.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned PW  = $clog2(N),
    localparam int unsigned PW1 = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant_c,
    output logic [PW-1:0] sel_c
);
    logic [PW-1:0] ptr;
    logic [PW:0]   cand;
    logic          found;

    // Scan N candidates starting at ptr, wrapping modulo N.
    always_comb begin
        grant_c = '0;
        sel_c   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PW1'(ptr) + PW1'(i);
            if (cand >= PW1'(N)) begin
                cand = cand - PW1'(N);
            end
            if (en && !found && req[cand[PW-1:0]]) begin
                found                  = 1'b1;
                sel_c                  = cand[PW-1:0];
                grant_c[cand[PW-1:0]]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (sel_c == PW'(N - 1)) ? '0 : sel_c + PW'(1);
        end
    end
endmodule

// File: rtl/atan2_share_ctrl.sv
// Shares one fixedpoint_arctan2 unit between NREQ requesters. A tag pipe moving in
// lock-step with the unit names the owner of each result; a blocked head stalls the unit.
module atan2_share_ctrl
    import fixedpoint::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = ATAN2_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  number [NREQ-1:0] req_y,
    input  number [NREQ-1:0] req_x,
    output logic [NREQ-1:0]  res_valid,
    input  logic [NREQ-1:0]  res_ready,
    output number            res_atan2,
    output number            res_r,
    output logic             u_in_valid,
    output number            u_y,
    output number            u_x,
    input  number            u_atan2,
    input  number            u_r,
    input  logic             u_out_valid,
    output logic             busy
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(LAT + 1);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t            tag_q [LAT];
    tag_t            head;
    tag_t            tag_in;
    logic [CW-1:0]   inflight;
    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  sel_c;
    logic            issue_c;
    logic            retire_c;
    logic            stall_c;
    logic            advance_c;
    logic            unused_u_out_valid;

    // The unit has no reset and its valid saturates, so ownership comes from the tag pipe only.
    assign unused_u_out_valid = u_out_valid;

    assign head      = tag_q[LAT-1];
    assign stall_c   = head.v & ~res_ready[head.id];
    // rst_n gates the enable so every output reads zero while reset is asserted.
    assign advance_c = rst_n & ~stall_c & ((|req_valid) | (inflight != '0));
    assign issue_c   = |grant_c;
    assign retire_c  = head.v & advance_c;
    assign tag_in    = '{v: issue_c, id: sel_c};

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (advance_c),
        .grant_c (grant_c),
        .sel_c   (sel_c)
    );

    assign u_in_valid = advance_c;
    assign req_ready  = grant_c;
    assign busy       = (inflight != '0);
    assign res_atan2  = head.v ? u_atan2 : '0;
    assign res_r      = head.v ? u_r     : '0;

    always_comb begin
        res_valid          = '0;
        res_valid[head.id] = head.v;
    end

    // Operands of the granted requester; zero on drain bubbles.
    always_comb begin
        u_y = '0;
        u_x = '0;
        if (issue_c) begin
            u_y = req_y[sel_c];
            u_x = req_x[sel_c];
        end
    end

    // Tag pipe and in-flight count move only when the unit advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
            inflight <= '0;
        end else if (advance_c) begin
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (issue_c && !retire_c) begin
                inflight <= inflight + CW'(1);
            end else if (!issue_c && retire_c) begin
                inflight <= inflight - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_atan2_share_ctrl.sv
// Bench for atan2_share_ctrl: behavioural CORDIC stand-in plus a scoreboard that predicts
// grants, stalls and result timing from issue order and advance counts.
module tb_atan2_share_ctrl;
    import fixedpoint::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = ATAN2_LAT;
    localparam real         SCALE = 4294967296.0;
    localparam real         TOL   = 1.0 / 16777216.0;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][64:0] req_y;
    logic [NREQ-1:0][64:0] req_x;
    logic [NREQ-1:0]       res_valid;
    logic [NREQ-1:0]       res_ready;
    logic [64:0]           res_atan2;
    logic [64:0]           res_r;
    logic                  u_in_valid;
    logic [64:0]           u_y;
    logic [64:0]           u_x;
    logic [64:0]           u_atan2;
    logic [64:0]           u_r;
    logic                  u_out_valid;
    logic                  busy;

    atan2_share_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_y       (req_y),
        .req_x       (req_x),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_atan2   (res_atan2),
        .res_r       (res_r),
        .u_in_valid  (u_in_valid),
        .u_y         (u_y),
        .u_x         (u_x),
        .u_atan2     (u_atan2),
        .u_r         (u_r),
        .u_out_valid (u_out_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Q32.32 conversions
    function automatic real to_real(input logic [64:0] v);
        longint s;
        s = longint'(v[63:0]);
        return real'(s) / SCALE;
    endfunction

    function automatic logic [64:0] to_fix(input real r);
        longint s;
        s = longint'(r * SCALE);
        return {s[63], s};
    endfunction

    function automatic logic [64:0] fx_atan2(input logic [64:0] y, input logic [64:0] x);
        return to_fix($atan2(to_real(y), to_real(x)));
    endfunction

    function automatic logic [64:0] fx_mag(input logic [64:0] y, input logic [64:0] x);
        real yr, xr;
        yr = to_real(y);
        xr = to_real(x);
        return to_fix($sqrt(yr * yr + xr * xr));
    endfunction

    function automatic logic [64:0] rand_num();
        longint v;
        v = longint'($urandom_range(0, 1 << 20)) - longint'(1 << 19);
        v = v <<< 13;
        return {v[63], v};
    endfunction

    function automatic logic near(input logic [64:0] v, input real ref_v);
        real d;
        d = to_real(v) - ref_v;
        return (d <= TOL) && (d >= -TOL);
    endfunction

    // CORDIC stand-in: no reset, valid stuck high, shifts only on u_in_valid.
    logic [64:0] ua [LAT];
    logic [64:0] ur [LAT];
    assign u_atan2     = ua[LAT-1];
    assign u_r         = ur[LAT-1];
    assign u_out_valid = 1'b1;

    always @(posedge clk) begin
        if (u_in_valid) begin
            ua[0] <= fx_atan2(u_y, u_x);
            ur[0] <= fx_mag(u_y, u_x);
            for (int i = 1; i < LAT; i++) begin
                ua[i] <= ua[i-1];
                ur[i] <= ur[i-1];
            end
        end
    end

    typedef struct {
        int          id;
        longint      a0;
        logic [64:0] a;
        logic [64:0] r;
    } item_t;

    item_t       sb[$];
    longint      adv_cnt = 0;
    int          rr = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          p_new = 0;
    bit          rdy_rand = 1'b0;
    int          block_id = -1;
    bit          vq [NREQ];
    logic [64:0] yq [NREQ];
    logic [64:0] xq [NREQ];

    logic [NREQ-1:0] obs_rr;
    bit              obs_vis;
    bit              obs_adv;
    int              obs_cyc;

    task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare combinational outputs, then advance the model.
    task automatic step();
        bit              vis, stall, any_req, adv;
        int              g, idx;
        logic [NREQ-1:0] e_rr, e_rv;
        logic [64:0]     e_a, e_r, e_y, e_x;
        item_t           it;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!vq[i] && ($urandom_range(99) < p_new)) begin
                vq[i] = 1'b1;
                yq[i] = rand_num();
                xq[i] = rand_num();
            end
            req_valid[i] = vq[i];
            req_y[i]     = yq[i];
            req_x[i]     = xq[i];
            res_ready[i] = rdy_rand ? ($urandom_range(99) < 75) : 1'b1;
            if (block_id == i) res_ready[i] = 1'b0;
        end
        #1;
        any_req = |req_valid;
        vis     = (sb.size() > 0) && (adv_cnt == sb[0].a0 + LAT);
        stall   = vis && !res_ready[sb[0].id];
        adv     = !stall && (any_req || sb.size() > 0);
        g       = -1;
        if (adv && any_req) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr + k) % NREQ;
                if (g < 0 && vq[idx]) g = idx;
            end
        end
        e_rr = '0;
        e_rv = '0;
        e_a  = '0;
        e_r  = '0;
        e_y  = '0;
        e_x  = '0;
        if (g >= 0) begin
            e_rr[g] = 1'b1;
            e_y     = yq[g];
            e_x     = xq[g];
        end
        if (vis) begin
            e_rv[sb[0].id] = 1'b1;
            e_a            = sb[0].a;
            e_r            = sb[0].r;
        end
        check_eq("u_in_valid", 65'(u_in_valid), 65'(adv));
        check_eq("req_ready",  65'(req_ready),  65'(e_rr));
        check_eq("res_valid",  65'(res_valid),  65'(e_rv));
        check_eq("busy",       65'(busy),       65'(sb.size() != 0));
        check_eq("res_atan2",  res_atan2,       e_a);
        check_eq("res_r",      res_r,           e_r);
        check_eq("u_y",        u_y,             e_y);
        check_eq("u_x",        u_x,             e_x);
        obs_rr  = req_ready;
        obs_vis = vis;
        obs_adv = u_in_valid;
        obs_cyc = cyc;
        if (adv && vis) it = sb.pop_front();
        if (g >= 0) begin
            it.id = g;
            it.a0 = adv_cnt;
            it.a  = fx_atan2(yq[g], xq[g]);
            it.r  = fx_mag(yq[g], xq[g]);
            sb.push_back(it);
            rr    = (g + 1) % NREQ;
            vq[g] = 1'b0;
        end
        if (adv) adv_cnt++;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < 400) begin
            step();
            n++;
            pend = sb.size() > 0;
            for (int i = 0; i < NREQ; i++) if (vq[i]) pend = 1'b1;
        end
        check_eq({tag, "_drained"}, 65'(sb.size()), 65'(0));
        step();
        check_eq({tag, "_busy"}, 65'(busy), 65'(0));
        check_eq({tag, "_idle"}, 65'(obs_adv), 65'(0));
    endtask

    // Lone request, optionally with a second one injected mid-drain.
    task automatic single_req(input string tag, input int id, input real y, input real x,
                              input real ea, input real er, input int late_id);
        int              g_cyc, v_cyc, nadv;
        logic [64:0]     a, r;
        logic [NREQ-1:0] rv, oh, oh_late;
        oh = '0;
        oh[id] = 1'b1;
        oh_late = '0;
        if (late_id >= 0) oh_late[late_id] = 1'b1;
        vq[id] = 1'b1;
        yq[id] = to_fix(y);
        xq[id] = to_fix(x);
        g_cyc = -1000;
        v_cyc = -1;
        nadv  = 0;
        a     = '0;
        r     = '0;
        rv    = '0;
        for (int n = 0; n < 200 && !(v_cyc >= 0 && sb.size() == 0); n++) begin
            step();
            if (n == 0) check_eq({tag, "_ready_first"}, 65'(obs_rr), 65'(oh));
            if (obs_adv) nadv++;
            if (g_cyc < 0 && obs_rr[id]) g_cyc = obs_cyc;
            if (obs_vis && v_cyc < 0) begin
                v_cyc = obs_cyc;
                a     = res_atan2;
                r     = res_r;
                rv    = res_valid;
            end
            if (late_id >= 0 && n == 9) begin
                vq[late_id] = 1'b1;
                yq[late_id] = rand_num();
                xq[late_id] = rand_num();
            end
            if (late_id >= 0 && n == 10) begin
                check_eq({tag, "_late_grant"}, 65'(obs_rr), 65'(oh_late));
                check_eq({tag, "_late_adv"},   65'(obs_adv), 65'(1));
            end
        end
        check_eq({tag, "_latency"},   65'(v_cyc - g_cyc), 65'(LAT));
        check_eq({tag, "_res_valid"}, 65'(rv), 65'(oh));
        check_eq({tag, "_atan2_tol"}, 65'(near(a, ea)), 65'(1));
        check_eq({tag, "_r_tol"},     65'(near(r, er)), 65'(1));
        if (late_id < 0) check_eq({tag, "_adv_cycles"}, 65'(nadv), 65'(LAT + 1));
        step();
        check_eq({tag, "_busy_after"}, 65'(busy), 65'(0));
        check_eq({tag, "_uin_after"},  65'(obs_adv), 65'(0));
    endtask

    initial begin
        int              gs [8];
        int              ngs, rr0;
        logic [64:0]     held;
        logic [NREQ-1:0] oh;

        for (int i = 0; i < NREQ; i++) begin
            vq[i] = 1'b0;
            yq[i] = '0;
            xq[i] = '0;
        end
        req_valid = '1;
        res_ready = '1;
        req_y     = '0;
        req_x     = '0;
        #3;
        check_eq("rst_req_ready",  65'(req_ready),  65'(0));
        check_eq("rst_res_valid",  65'(res_valid),  65'(0));
        check_eq("rst_busy",       65'(busy),       65'(0));
        check_eq("rst_u_in_valid", 65'(u_in_valid), 65'(0));
        check_eq("rst_res_atan2",  res_atan2,       65'(0));
        check_eq("rst_u_y",        u_y,             65'(0));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        single_req("t_diag", 0, 1.0, 1.0, 0.7853981633974483, 1.4142135623730951, -1);
        single_req("t_down", 2, -2.0, 0.0, -1.5707963267949, 2.0, -1);
        single_req("t_drain", 1, 0.5, -1.5, $atan2(0.5, -1.5), $sqrt(2.5), 3);

        // Reset with five samples in flight; stale unit data must never surface.
        p_new = 100;
        repeat (5) step();
        p_new = 0;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = '1;
        #1;
        check_eq("mid_rst_res_valid", 65'(res_valid),  65'(0));
        check_eq("mid_rst_busy",      65'(busy),       65'(0));
        check_eq("mid_rst_u_in",      65'(u_in_valid), 65'(0));
        check_eq("mid_rst_ready",     65'(req_ready),  65'(0));
        @(negedge clk);
        #1;
        check_eq("mid_rst_res_valid2", 65'(res_valid), 65'(0));
        check_eq("mid_rst_busy2",      65'(busy),      65'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        sb.delete();
        rr = 0;
        for (int i = 0; i < NREQ; i++) vq[i] = 1'b0;
        repeat (60) step();

        // All requesters continuously valid: strict rotation, one grant per clock.
        for (int k = 0; k < 8; k++) gs[k] = -1;
        ngs   = 0;
        rr0   = rr;
        p_new = 100;
        for (int n = 0; n < 12; n++) begin
            step();
            for (int k = 0; k < NREQ; k++) begin
                if (obs_rr[k] && ngs < 8) begin
                    gs[ngs] = k;
                    ngs++;
                end
            end
        end
        for (int k = 0; k < 8; k++) check_eq("rr_order", 65'(gs[k]), 65'((rr0 + k) % NREQ));
        repeat (40) step();

        // Head owner refuses its result for 10 clocks.
        block_id = sb[0].id;
        held     = sb[0].a;
        oh       = '0;
        oh[block_id] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            check_eq("stall_u_in",      65'(obs_adv),   65'(0));
            check_eq("stall_req_ready", 65'(obs_rr),    65'(0));
            check_eq("stall_res_valid", 65'(res_valid), 65'(oh));
            check_eq("stall_hold",      res_atan2,      held);
        end
        block_id = -1;
        p_new    = 0;
        drain("t_stall");

        // Random traffic with random backpressure.
        p_new    = 40;
        rdy_rand = 1'b1;
        repeat (600) step();
        p_new    = 0;
        rdy_rand = 1'b0;
        drain("t_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
